frame_mode_control: RTL and testbench
=====================================

// Module: frame_mode_control
// PURPOSE
// Parametrised successor to the single-switch system controller: sequences camera config after
// reset, then drives enables for N_STAGES bypassable processing stages (Gaussian, future filters).
// Mode changes take effect only at a frame boundary and are wrapped in a pipeline flush.
// Sits in the i_sysclk domain between board switches, the camera block (sof, cfg) and the pipeline.
// PARAMETERS
// N_STAGES      2       number of independently enabled processing stages (1..8)
// CFG_DELAY     125000  cycles from reset release to first o_cfg_start pulse (>=2)
// CFG_TIMEOUT   2500000 cycles to wait for i_cfg_done before re-issuing o_cfg_start (>=2)
// FLUSH_CYCLES  16      length of o_pipe_flush assertion per mode change (>=1)
// SW_STABLE     62500   consecutive cycles a synchronised switch vector must hold to be accepted (>=1)
// FCW           16      width of frame counter
// PORTS
// i_sysclk        in   1         system clock
// i_rstn          in   1         asynchronous active-low reset
// i_sof           in   1         start-of-frame, single-cycle pulse, i_sysclk domain
// i_cfg_done      in   1         camera configuration complete (level)
// i_sw_enable     in   N_STAGES  raw board switches, asynchronous; bit k requests stage k
// o_cfg_start     out  1         single-cycle config start pulse
// o_stage_enable  out  N_STAGES  registered stage enables to the pipeline
// o_pipe_flush    out  1         registered pipeline flush
// o_state         out  3         current FSM state encoding (status LEDs)
// o_frame_count   out  FCW       frames seen since config done, wraps modulo 2^FCW
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, state WAIT (0), all counters 0; mid-operation reset
//   aborts any flush/config immediately, enables drop to 0 in same cycle.
// - i_sw_enable passes a 2-FF synchroniser per bit, then a stability filter: req <= sync vector after it
//   is unchanged for SW_STABLE cycles; any change restarts the count. req resets to 0.
// - FSM states/encoding: WAIT=0, CFG=1, RUN=2, ARM=3, FLUSH=4.
// - WAIT: count CFG_DELAY cycles -> CFG. o_cfg_start is high exactly in first cycle of CFG.
// - CFG: if i_cfg_done=1 (checked from 2nd CFG cycle on) -> RUN; if CFG_TIMEOUT cycles elapse
//   without it, re-pulse o_cfg_start one cycle and restart timeout (retry forever).
// - RUN: if req != o_stage_enable -> ARM next cycle.
// - ARM: wait for i_sof. If req returns to o_stage_enable before sof -> RUN, no flush.
//   On i_sof: latch req, -> FLUSH. sof on the same cycle ARM is entered is not used.
// - FLUSH: o_pipe_flush high for exactly FLUSH_CYCLES cycles starting the cycle after the sof;
//   o_stage_enable takes latched req on first flush cycle; req changes ignored; then -> RUN
//   (a pending difference is re-armed for the next frame via RUN->ARM).
// - o_frame_count increments on every i_sof while in RUN/ARM/FLUSH; sof in WAIT/CFG ignored; wraps to 0.
// - i_cfg_done deasserting after RUN is ignored (no re-config without reset).
// - All outputs registered; no combinational path input->output.
// TESTING (CFG_DELAY=8, CFG_TIMEOUT=50, FLUSH_CYCLES=4, SW_STABLE=3, N_STAGES=2, FCW=4)
// - Release reset, cfg_done=1 at cycle 20 -> o_cfg_start single pulse at cycle 8, state 1 then 2 at 21.
// - Hold cfg_done=0 -> o_cfg_start pulses at 8, 58, 108; cfg_done=1 -> RUN, no further pulses.
// - In RUN set sw=2'b01, sof 30 cycles later -> ARM; flush high 4 cycles after sof, enable=01 on 1st.
// - sw=01 then back to 00 before any sof -> ARM then RUN, no flush, enable stays 00.
// - sw glitch 01 for 2 cycles only -> req unchanged, state stays RUN; 17 sofs in RUN -> frame_count=1.
// - Assert i_rstn=0 during FLUSH cycle 2 -> flush, enable, cfg_start, frame_count all 0 same cycle; WAIT.

Source files
------------

// File: rtl/frame_mode_control.sv
// Frame-synchronous mode controller: sequences camera configuration after reset, then
// applies debounced stage-enable changes only at frame boundaries, wrapped in a pipeline flush.
module frame_mode_control #(
    parameter int N_STAGES     = 2,
    parameter int CFG_DELAY    = 125000,
    parameter int CFG_TIMEOUT  = 2500000,
    parameter int FLUSH_CYCLES = 16,
    parameter int SW_STABLE    = 62500,
    parameter int FCW          = 16
) (
    input  logic                i_sysclk,
    input  logic                i_rstn,
    input  logic                i_sof,
    input  logic                i_cfg_done,
    input  logic [N_STAGES-1:0] i_sw_enable,
    output logic                o_cfg_start,
    output logic [N_STAGES-1:0] o_stage_enable,
    output logic                o_pipe_flush,
    output logic [2:0]          o_state,
    output logic [FCW-1:0]      o_frame_count
);

    localparam int CNT_MAX_A = (CFG_DELAY > CFG_TIMEOUT) ? CFG_DELAY : CFG_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > FLUSH_CYCLES) ? CNT_MAX_A : FLUSH_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int SW_W      = $clog2(SW_STABLE + 1);

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_CFG   = 3'd1,
        ST_RUN   = 3'd2,
        ST_ARM   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       cnt_r;
    logic [N_STAGES-1:0] sync1_r;
    logic [N_STAGES-1:0] sync2_r;
    logic [N_STAGES-1:0] prev_r;
    logic [N_STAGES-1:0] req_r;
    logic [SW_W-1:0]     stab_cnt_r;
    logic                frame_state_s;

    assign o_state       = state_r;
    assign frame_state_s = (state_r == ST_RUN) || (state_r == ST_ARM) || (state_r == ST_FLUSH);

    // Two-flop synchroniser followed by a stability filter producing the accepted request vector.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_r    <= {N_STAGES{1'b0}};
            sync2_r    <= {N_STAGES{1'b0}};
            prev_r     <= {N_STAGES{1'b0}};
            req_r      <= {N_STAGES{1'b0}};
            stab_cnt_r <= {SW_W{1'b0}};
        end else begin
            sync1_r <= i_sw_enable;
            sync2_r <= sync1_r;
            if (sync2_r != prev_r) begin
                prev_r     <= sync2_r;
                stab_cnt_r <= {SW_W{1'b0}};
            end else if (stab_cnt_r == SW_W'(SW_STABLE - 1)) begin
                req_r <= prev_r;
            end else begin
                stab_cnt_r <= stab_cnt_r + SW_W'(1);
            end
        end
    end

    // Frame counter: only frames after configuration completes are counted.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_frame_count <= {FCW{1'b0}};
        end else if (i_sof && frame_state_s) begin
            o_frame_count <= o_frame_count + FCW'(1);
        end
    end

    // Main sequencer: config bring-up, then frame-aligned mode changes with flush.
    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r        <= ST_WAIT;
            cnt_r          <= {CW{1'b0}};
            o_cfg_start    <= 1'b0;
            o_stage_enable <= {N_STAGES{1'b0}};
            o_pipe_flush   <= 1'b0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (cnt_r == CW'(CFG_DELAY - 1)) begin
                        state_r     <= ST_CFG;
                        o_cfg_start <= 1'b1;
                        cnt_r       <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_CFG: begin
                    // cnt_r is zero in each cycle that carries a cfg_start pulse, so done is ignored there.
                    if ((cnt_r != {CW{1'b0}}) && i_cfg_done) begin
                        state_r     <= ST_RUN;
                        o_cfg_start <= 1'b0;
                        cnt_r       <= {CW{1'b0}};
                    end else if (cnt_r == CW'(CFG_TIMEOUT - 1)) begin
                        o_cfg_start <= 1'b1;
                        cnt_r       <= {CW{1'b0}};
                    end else begin
                        o_cfg_start <= 1'b0;
                        cnt_r       <= cnt_r + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (req_r != o_stage_enable) begin
                        state_r <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (req_r == o_stage_enable) begin
                        state_r <= ST_RUN;
                    end else if (i_sof) begin
                        state_r        <= ST_FLUSH;
                        o_stage_enable <= req_r;
                        o_pipe_flush   <= 1'b1;
                        cnt_r          <= {CW{1'b0}};
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == CW'(FLUSH_CYCLES - 1)) begin
                        state_r      <= ST_RUN;
                        o_pipe_flush <= 1'b0;
                        cnt_r        <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r        <= ST_WAIT;
                    cnt_r          <= {CW{1'b0}};
                    o_cfg_start    <= 1'b0;
                    o_stage_enable <= {N_STAGES{1'b0}};
                    o_pipe_flush   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_mode_control.sv
// Directed bench for frame_mode_control with small parameters; expected values hand-computed.
module tb_frame_mode_control;

    localparam int N_STAGES = 2;
    localparam int FCW      = 4;

    logic                i_sysclk = 1'b0;
    logic                i_rstn;
    logic                i_sof;
    logic                i_cfg_done;
    logic [N_STAGES-1:0] i_sw_enable;
    logic                o_cfg_start;
    logic [N_STAGES-1:0] o_stage_enable;
    logic                o_pipe_flush;
    logic [2:0]          o_state;
    logic [FCW-1:0]      o_frame_count;

    int checks = 0;
    int errors = 0;

    always #5 i_sysclk = ~i_sysclk;

    frame_mode_control #(
        .N_STAGES(N_STAGES), .CFG_DELAY(8), .CFG_TIMEOUT(50),
        .FLUSH_CYCLES(4), .SW_STABLE(3), .FCW(FCW)
    ) dut (
        .i_sysclk(i_sysclk), .i_rstn(i_rstn), .i_sof(i_sof), .i_cfg_done(i_cfg_done),
        .i_sw_enable(i_sw_enable), .o_cfg_start(o_cfg_start), .o_stage_enable(o_stage_enable),
        .o_pipe_flush(o_pipe_flush), .o_state(o_state), .o_frame_count(o_frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_sysclk);
            #1;
        end
    endtask

    // Cycle 0 is the cycle right after reset release; checks are made after each edge.
    task automatic run_cfg(input int done_cyc, input int last_cyc);
        int exp_start;
        int exp_state;
        for (int c = 1; c <= last_cyc; c++) begin
            tick(1);
            exp_start = (c >= 8 && c <= done_cyc && ((c - 8) % 50) == 0) ? 1 : 0;
            exp_state = (c < 8) ? 0 : ((c <= done_cyc) ? 1 : 2);
            chk("cfg_start", 32'(o_cfg_start), 32'(exp_start));
            chk("cfg_state", 32'(o_state), 32'(exp_state));
            if (c == done_cyc) i_cfg_done = 1'b1;
        end
    endtask

    initial begin
        i_rstn      = 1'b0;
        i_sof       = 1'b0;
        i_cfg_done  = 1'b0;
        i_sw_enable = 2'b00;
        tick(3);
        chk("rst_cfg_start", 32'(o_cfg_start), 32'd0);
        chk("rst_enable", 32'(o_stage_enable), 32'd0);
        chk("rst_flush", 32'(o_pipe_flush), 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_fcount", 32'(o_frame_count), 32'd0);
        i_rstn = 1'b1;

        // Config done arrives at cycle 20: single pulse at 8, RUN from 21.
        run_cfg(20, 30);

        // Request 01 then back to 00 before any frame: ARM then RUN without flush.
        i_sw_enable = 2'b01;
        for (int i = 1; i <= 14; i++) begin
            tick(1);
            chk("abort_flush", 32'(o_pipe_flush), 32'd0);
            chk("abort_enable", 32'(o_stage_enable), 32'd0);
            if (i == 6)  chk("abort_run", 32'(o_state), 32'd2);
            if (i == 7)  chk("abort_arm", 32'(o_state), 32'd3);
            if (i == 13) chk("abort_arm_hold", 32'(o_state), 32'd3);
            if (i == 14) chk("abort_back_run", 32'(o_state), 32'd2);
            if (i == 7)  i_sw_enable = 2'b00;
        end

        // Two-cycle glitch is filtered out.
        i_sw_enable = 2'b01;
        tick(2);
        i_sw_enable = 2'b00;
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            chk("glitch_state", 32'(o_state), 32'd2);
        end

        // 17 frames in RUN: 4-bit counter wraps to 1.
        for (int k = 1; k <= 17; k++) begin
            i_sof = 1'b1;
            tick(1);
            i_sof = 1'b0;
            if (k == 1) chk("fcount_first", 32'(o_frame_count), 32'd1);
            tick(2);
        end
        chk("fcount_wrap", 32'(o_frame_count), 32'd1);

        // Request 01, frame arrives 30 cycles later: 4-cycle flush, enable applied on first.
        i_sw_enable = 2'b01;
        tick(6);
        chk("mode_run", 32'(o_state), 32'd2);
        tick(1);
        chk("mode_arm", 32'(o_state), 32'd3);
        tick(30);
        chk("mode_arm_wait", 32'(o_state), 32'd3);
        chk("mode_arm_noflush", 32'(o_pipe_flush), 32'd0);
        chk("mode_arm_enable", 32'(o_stage_enable), 32'd0);
        i_sof = 1'b1;
        tick(1);
        i_sof = 1'b0;
        chk("flush_state", 32'(o_state), 32'd4);
        chk("flush_c1", 32'(o_pipe_flush), 32'd1);
        chk("flush_enable", 32'(o_stage_enable), 32'd1);
        chk("flush_fcount", 32'(o_frame_count), 32'd2);
        for (int i = 2; i <= 4; i++) begin
            tick(1);
            chk("flush_hold", 32'(o_pipe_flush), 32'd1);
            chk("flush_enable_hold", 32'(o_stage_enable), 32'd1);
        end
        tick(1);
        chk("flush_end", 32'(o_pipe_flush), 32'd0);
        chk("flush_end_state", 32'(o_state), 32'd2);
        tick(1);
        chk("post_flush_run", 32'(o_state), 32'd2);

        // Reset asserted during the second flush cycle clears everything at once.
        i_sw_enable = 2'b10;
        tick(7);
        chk("rearm_state", 32'(o_state), 32'd3);
        i_sof = 1'b1;
        tick(1);
        i_sof = 1'b0;
        chk("rearm_enable", 32'(o_stage_enable), 32'd2);
        chk("rearm_fcount", 32'(o_frame_count), 32'd3);
        tick(1);
        chk("rearm_flush_c2", 32'(o_pipe_flush), 32'd1);
        i_cfg_done  = 1'b0;
        i_sw_enable = 2'b00;
        i_rstn      = 1'b0;
        #1;
        chk("midrst_flush", 32'(o_pipe_flush), 32'd0);
        chk("midrst_enable", 32'(o_stage_enable), 32'd0);
        chk("midrst_cfg_start", 32'(o_cfg_start), 32'd0);
        chk("midrst_fcount", 32'(o_frame_count), 32'd0);
        chk("midrst_state", 32'(o_state), 32'd0);
        tick(2);
        i_rstn = 1'b1;

        // Config never completes until cycle 110: retries at 8, 58, 108, then RUN.
        run_cfg(110, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
